// File: rtl/counter_run_ctrl.sv
// Sequencer driving an up-counter through N clear/enable/sample runs.
// Optional COUNTER_CTRL_PAUSE_EN adds a pause input that stalls RUN.
module counter_run_ctrl #(
    parameter int LEN_W = 8,
    parameter int REP_W = 4,
    parameter int GAP_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] run_len,
    input  logic [REP_W-1:0] rep_cnt,
    input  logic [GAP_W-1:0] gap_len,
`ifdef COUNTER_CTRL_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             abort,
    input  logic [CNT_W-1:0] counter_out,
    output logic             cnt_reset,
    output logic             cnt_enable,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [REP_W-1:0] runs_left,
    output logic [CNT_W-1:0] last_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SAMPLE,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_cfg_q, len_cfg_d;
    logic [GAP_W-1:0] gap_cfg_q, gap_cfg_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [REP_W-1:0] runs_left_q, runs_left_d;
    logic [CNT_W-1:0] last_count_q, last_count_d;
    logic             err_q, err_d;
    logic             cnt_reset_q, cnt_reset_d;
    logic             run_q, run_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pause_w;

`ifdef COUNTER_CTRL_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        len_cfg_d    = len_cfg_q;
        gap_cfg_d    = gap_cfg_q;
        len_d        = len_q;
        gap_d        = gap_q;
        runs_left_d  = runs_left_q;
        last_count_d = last_count_q;
        err_d        = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (run_len != '0 && rep_cnt != '0) begin
                            len_cfg_d   = run_len;
                            gap_cfg_d   = gap_len;
                            runs_left_d = rep_cnt;
                            state_d     = S_CLEAR;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    len_d   = len_cfg_q;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    // paused cycles do not count toward the run length
                    if (!pause_w) begin
                        len_d = len_q - 1'b1;
                        if (len_q == LEN_W'(1)) begin
                            state_d = S_SAMPLE;
                        end
                    end
                end
                S_SAMPLE: begin
                    last_count_d = counter_out;
                    runs_left_d  = runs_left_q - 1'b1;
                    if (runs_left_q == REP_W'(1)) begin
                        state_d = S_DONE;
                    end else if (gap_cfg_q != '0) begin
                        gap_d   = gap_cfg_q;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
                S_GAP: begin
                    gap_d = gap_q - 1'b1;
                    if (gap_q == GAP_W'(1)) begin
                        state_d = S_CLEAR;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        cnt_reset_d = (state_d == S_CLEAR);
        run_d       = (state_d == S_RUN);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_cfg_q    <= '0;
            gap_cfg_q    <= '0;
            len_q        <= '0;
            gap_q        <= '0;
            runs_left_q  <= '0;
            last_count_q <= '0;
            err_q        <= 1'b0;
            cnt_reset_q  <= 1'b0;
            run_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_cfg_q    <= len_cfg_d;
            gap_cfg_q    <= gap_cfg_d;
            len_q        <= len_d;
            gap_q        <= gap_d;
            runs_left_q  <= runs_left_d;
            last_count_q <= last_count_d;
            err_q        <= err_d;
            cnt_reset_q  <= cnt_reset_d;
            run_q        <= run_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign cnt_reset  = cnt_reset_q;
    assign cnt_enable = run_q & ~pause_w;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign runs_left  = runs_left_q;
    assign last_count = last_count_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Bench for counter_run_ctrl: per-cycle trace built from the run schedule.
// An attached up-counter model supplies counter_out.
module tb_counter_run_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] run_len = '0;
    logic [3:0] rep_cnt = '0;
    logic [3:0] gap_len = '0;
`ifdef COUNTER_CTRL_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic       abort = 1'b0;
    logic [3:0] counter_out = '0;
    logic       cnt_reset, cnt_enable, busy, done, err;
    logic [3:0] runs_left, last_count;

    int checks = 0;
    int errors = 0;

    counter_run_ctrl dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .run_len(run_len),
        .rep_cnt(rep_cnt),
        .gap_len(gap_len),
`ifdef COUNTER_CTRL_PAUSE_EN
        .pause(pause),
`endif
        .abort(abort),
        .counter_out(counter_out),
        .cnt_reset(cnt_reset),
        .cnt_enable(cnt_enable),
        .busy(busy),
        .done(done),
        .err(err),
        .runs_left(runs_left),
        .last_count(last_count)
    );

    always #5 clock = ~clock;

    // controlled counter: synchronous clear, count when enabled
    always_ff @(posedge clock) begin
        if (cnt_reset) counter_out <= '0;
        else if (cnt_enable) counter_out <= counter_out + 4'd1;
    end

    typedef struct packed {
        logic       p;
        logic       rs;
        logic       en;
        logic       bz;
        logic       dn;
        logic       er;
        logic [3:0] rl;
        logic [3:0] lc;
    } cyc_t;

    cyc_t q[$];
    int   m_rl = 0;
    int   m_lc = 0;

    task automatic chk(input string tag, input logic [12:0] exp_v);
        logic [12:0] obs;
        obs = {cnt_reset, cnt_enable, busy, done, err, runs_left, last_count};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input string tag, input logic e_err);
        chk(tag, {1'b0, 1'b0, 1'b0, 1'b0, e_err, 4'(m_rl), 4'(m_lc)});
    endtask

    task automatic push(input logic p, rs, en, bz, dn, input int rl, lc);
        cyc_t c;
        c.p  = p;
        c.rs = rs;
        c.en = en;
        c.bz = bz;
        c.dn = dn;
        c.er = 1'b0;
        c.rl = 4'(rl);
        c.lc = 4'(lc);
        q.push_back(c);
    endtask

    // expected trace of one accepted command; pn pause cycles after pat enables
    task automatic build(input int rl, rc, gl, pat, pn);
        q.delete();
        for (int r = 0; r < rc; r++) begin
            push(0, 1, 0, 1, 0, rc - r, m_lc);
            for (int k = 0; k < rl; k++) begin
                if (r == 0 && k == pat)
                    for (int j = 0; j < pn; j++) push(1, 0, 0, 1, 0, rc - r, m_lc);
                push(0, 0, 1, 1, 0, rc - r, m_lc);
            end
            push(0, 0, 0, 1, 0, rc - r, m_lc);
            m_lc = rl % 16;
            if (r == rc - 1) push(0, 0, 0, 1, 1, 0, m_lc);
            else for (int g = 0; g < gl; g++) push(0, 0, 0, 1, 0, rc - r - 1, m_lc);
        end
        push(0, 0, 0, 0, 0, 0, m_lc);
        m_rl = 0;
    endtask

    // issue start and follow the trace; cut>=0 stops mid-cycle after entry cut
    task automatic go(input string tag, input int rl, rc, gl, cut);
        run_len = 8'(rl);
        rep_cnt = 4'(rc);
        gap_len = 4'(gl);
        start   = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < int'(q.size()); i++) begin
`ifdef COUNTER_CTRL_PAUSE_EN
            pause = q[i].p;
`endif
            #1;
            chk($sformatf("%s[%0d]", tag, i),
                {q[i].rs, q[i].en, q[i].bz, q[i].dn, q[i].er, q[i].rl, q[i].lc});
            if (i == cut) return;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        int rl, rc, gl, lc0;
        #2;
        chk_idle("reset_async", 1'b0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1 chk_idle("reset_state", 1'b0);
        @(posedge clock); #1;

        build(5, 1, 0, -1, 0);
        go("t1_single", 5, 1, 0, -1);

        build(20, 3, 2, -1, 0);
        go("t2_wrap", 20, 3, 2, -1);

        build(3, 3, 0, -1, 0);
        go("gap0", 3, 3, 0, -1);

        build(1, 2, 1, -1, 0);
        go("len1", 1, 2, 1, -1);

        build(255, 1, 0, -1, 0);
        go("len255", 255, 1, 0, -1);

        for (int n = 0; n < 2; n++) begin
            run_len = (n == 0) ? 8'd0 : 8'd7;
            rep_cnt = (n == 0) ? 4'd3 : 4'd0;
            start   = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            #1 chk_idle($sformatf("t3_err%0d", n), 1'b1);
            @(posedge clock); #2;
            chk_idle($sformatf("t3_errclr%0d", n), 1'b0);
        end

        lc0 = m_lc;
        build(10, 2, 1, -1, 0);
        go("t4_abort", 10, 2, 1, 3);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        m_lc = lc0;
        m_rl = 2;
        for (int i = 0; i < 3; i++) begin
            #1 chk_idle($sformatf("t4_idle%0d", i), 1'b0);
            @(posedge clock); #1;
        end
        build(6, 2, 3, -1, 0);
        go("t4_restart", 6, 2, 3, -1);

        build(12, 2, 1, -1, 0);
        go("t5_pre", 12, 2, 1, 5);
        #2 reset = 1'b1;
        m_rl = 0;
        m_lc = 0;
        #1 chk_idle("t5_async", 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1 chk_idle("t5_release", 1'b0);
        @(posedge clock); #1;
        build(4, 2, 2, -1, 0);
        go("t5_restart", 4, 2, 2, -1);

`ifdef COUNTER_CTRL_PAUSE_EN
        build(5, 1, 0, 2, 3);
        go("t6_pause", 5, 1, 0, -1);
        pause = 1'b0;
`endif

        for (int n = 0; n < 8; n++) begin
            rl = int'($urandom_range(1, 24));
            rc = int'($urandom_range(1, 4));
            gl = int'($urandom_range(0, 3));
            build(rl, rc, gl, -1, 0);
            go($sformatf("rand%0d", n), rl, rc, gl, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
